// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check
//   Frame-level checker for a UART receiver. A front end detects the start
//   edge and samples each bit at mid-bit. This block walks the frame
//   (start, data LSB-first, optional parity, stop), assembles the word and
//   flags start, parity and stop errors.
//
// Parameters
//   DATA_WIDTH  : data bits per frame (5..8)
//
// Ports
//   clk2        : in  oversampling clock; all state changes on its rising edge
//   rst         : in  asynchronous reset, active low
//   frame_start : in  pulse, start-bit falling edge seen on the line
//   bit_valid   : in  strobe, bit_value holds a fresh mid-bit sample
//   bit_value   : in  sampled serial bit
//   parity_en   : in  frame carries a parity bit (latched at frame start)
//   parity_type : in  0 = even, 1 = odd (latched at frame start)
//   p_data      : out last good received word
//   data_valid  : out pulse, p_data just updated
//   parity_err  : out pulse, parity mismatch in the frame just ended
//   stop_err    : out pulse, stop bit sampled as 0
//   start_err   : out pulse, start bit sampled as 1
//   busy        : out high whenever the FSM is not idle
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk2,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  bit_valid,
   input  logic                  bit_value,
   input  logic                  parity_en,
   input  logic                  parity_type,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  parity_err,
   output logic                  stop_err,
   output logic                  start_err,
   output logic                  busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // A 3-bit index covers DATA_WIDTH up to 8.
   localparam logic [2:0] LAST_IDX = 3'(DATA_WIDTH - 1);

   logic [2:0]            state_q,      state_d;
   logic [DATA_WIDTH-1:0] shift_q,      shift_d;
   logic [2:0]            idx_q,        idx_d;
   logic                  par_en_q,     par_en_d;
   logic                  par_type_q,   par_type_d;
   logic                  frame_err_q,  frame_err_d;
   logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  parity_err_q, parity_err_d;
   logic                  stop_err_q,   stop_err_d;
   logic                  start_err_q,  start_err_d;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      par_en_d     = par_en_q;
      par_type_d   = par_type_q;
      frame_err_d  = frame_err_q;
      p_data_d     = p_data_q;
      // Status outputs are single-cycle pulses: cleared unless set below.
      data_valid_d = 1'b0;
      parity_err_d = 1'b0;
      stop_err_d   = 1'b0;
      start_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // bit_valid is deliberately not looked at here, even in the
            // same cycle as frame_start.
            if (frame_start) begin
               state_d     = START;
               par_en_d    = parity_en;
               par_type_d  = parity_type;
               frame_err_d = 1'b0;
               idx_d       = 3'd0;
            end
         end
         START: begin
            if (bit_valid) begin
               if (!bit_value) begin
                  state_d = DATA;
               end else begin
                  // Line went back high: treat it as a glitch, not a frame.
                  state_d     = IDLE;
                  start_err_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (bit_valid) begin
               // LSB arrives first, so shift right and insert at the MSB.
               // After DATA_WIDTH bits the word sits in place.
               shift_d = {bit_value, shift_q[DATA_WIDTH-1:1]};
               if (idx_q == LAST_IDX) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_valid) begin
               if (bit_value != ((^shift_q) ^ par_type_q)) begin
                  frame_err_d = 1'b1;
               end
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_valid) begin
               state_d      = IDLE;
               stop_err_d   = ~bit_value;
               parity_err_d = frame_err_q;
               if (bit_value && !frame_err_q) begin
                  data_valid_d = 1'b1;
                  p_data_d     = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         idx_q        <= 3'd0;
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         stop_err_q   <= 1'b0;
         start_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         par_en_q     <= par_en_d;
         par_type_q   <= par_type_d;
         frame_err_q  <= frame_err_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         stop_err_q   <= stop_err_d;
         start_err_q  <= start_err_d;
      end
   end

   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign parity_err = parity_err_q;
   assign stop_err   = stop_err_q;
   assign start_err  = start_err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check
//   Drives whole frames (directed cases plus random ones) into
//   uart_rx_frame_check. The expected result of each frame is worked out
//   from the frame contents: the word, its parity, and the stop bit.
module tb_uart_rx_frame_check;

   localparam int DW = 8;

   logic          clk2 = 1'b0;
   logic          rst;
   logic          frame_start;
   logic          bit_valid;
   logic          bit_value;
   logic          parity_en;
   logic          parity_type;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          parity_err;
   logic          stop_err;
   logic          start_err;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model_pdata = '0;

   uart_rx_frame_check #(.DATA_WIDTH(DW)) dut (
      .clk2        (clk2),
      .rst         (rst),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .bit_value   (bit_value),
      .parity_en   (parity_en),
      .parity_type (parity_type),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .parity_err  (parity_err),
      .stop_err    (stop_err),
      .start_err   (start_err),
      .busy        (busy)
   );

   always #5 clk2 = ~clk2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk2);
      #1;
   endtask

   // A few random idle cycles, then one bit_valid strobe.
   task automatic send_bit(input logic b);
      repeat ($urandom_range(0, 2)) begin
         bit_valid = 1'b0;
         bit_value = 1'($urandom);
         tick();
      end
      bit_valid = 1'b1;
      bit_value = b;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_pulses"}, {data_valid, parity_err, stop_err, start_err}, 4'b0000);
      check({tag, "_pdata"}, p_data, model_pdata);
   endtask

   task automatic begin_frame(input logic pen, input logic ptype);
      frame_start = 1'b1;
      parity_en   = pen;
      parity_type = ptype;
      bit_valid   = 1'($urandom);   // must be ignored in this cycle
      bit_value   = 1'($urandom);
      tick();
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      // Scramble the live settings; the frame must keep the latched ones.
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
      check("busy_after_start", busy, 1);
   endtask

   task automatic run_frame(input logic sbit, input logic [DW-1:0] d,
                            input logic pen, input logic ptype,
                            input logic pbit, input logic stop, input bit inject);
      logic exp_perr;
      logic exp_dv;
      begin_frame(pen, ptype);
      send_bit(sbit);
      if (sbit) begin
         check("start_err_pulse", {start_err, busy, data_valid}, 3'b100);
         tick();
         check("start_err_len", start_err, 0);
         for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b1;
            bit_value = 1'($urandom);
            tick();
            check("post_glitch_busy", busy, 0);
            check_quiet("post_glitch");
         end
         bit_valid = 1'b0;
         return;
      end
      for (int i = 0; i < DW; i++) begin
         if (inject && i == 3) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("busy_inject", busy, 1);
         end
         send_bit(d[i]);
         check("busy_data", busy, 1);
      end
      if (pen) send_bit(pbit);
      send_bit(stop);
      // Even parity: parity bit equals the count of ones mod 2; odd inverts it.
      exp_perr = pen && (pbit != (1'($countones(d) % 2) ^ ptype));
      exp_dv   = stop && !exp_perr;
      if (exp_dv) model_pdata = d;
      check("data_valid", data_valid, exp_dv);
      check("parity_err", parity_err, exp_perr);
      check("stop_err", stop_err, !stop);
      check("start_err_none", start_err, 0);
      check("p_data", p_data, model_pdata);
      check("busy_end", busy, 0);
      tick();
      check_quiet("after_frame");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; bit_value = 1'b0;
      parity_en = 1'b0; parity_type = 1'b0;
      tick(); tick();
      check("reset_outputs", {p_data, data_valid, parity_err, stop_err, start_err, busy}, '0);
      @(negedge clk2) rst = 1'b1;
      tick();

      // No parity, 0xA5.
      run_frame(0, 8'hA5, 0, 0, 0, 1, 0);
      check("a5_word", p_data, 8'hA5);
      // Even parity, good then bad parity bit.
      run_frame(0, 8'h3C, 1, 0, 0, 1, 0);
      run_frame(0, 8'h3C, 1, 0, 1, 1, 0);
      check("3c_hold", p_data, 8'h3C);
      // Odd parity, correct parity bit, bad stop bit.
      run_frame(0, 8'h01, 1, 1, 0, 0, 0);
      // Both errors together.
      run_frame(0, 8'h01, 1, 1, 1, 0, 0);
      // Start glitch.
      run_frame(1, 8'h55, 0, 0, 0, 1, 0);
      // frame_start during DATA is ignored.
      run_frame(0, 8'hC3, 0, 0, 0, 1, 1);

      // Reset after 4 data bits, then a clean frame.
      begin_frame(0, 0);
      send_bit(0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom));
      #2 rst = 1'b0;
      #1;
      check("midframe_reset", {p_data, data_valid, parity_err, stop_err, start_err, busy}, '0);
      model_pdata = '0;
      @(negedge clk2) rst = 1'b1;
      tick();
      check_quiet("post_reset");
      run_frame(0, 8'h81, 0, 0, 0, 1, 0);
      check("81_word", p_data, 8'h81);

      // Random frames.
      for (int n = 0; n < 150; n++) begin
         run_frame(($urandom_range(0, 9) == 0), DW'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                   bit'($urandom));
         repeat ($urandom_range(0, 3)) begin
            bit_valid = 1'($urandom);
            bit_value = 1'($urandom);
            tick();
            check_quiet("idle_noise");
         end
         bit_valid = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
